// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard detection and forwarding control for a classic five-stage pipeline
// with a multi-cycle HI/LO (multiply/divide) unit.
//
//   - Combinational forward selects for the ID-stage branch comparator and
//     the EX-stage ALU operands (00 none, 01 from MEM, 10 from WB).
//   - Stall generation for load-use, branch-operand and HI/LO-busy hazards.
//   - Squash of the branch-likely delay slot when the branch is not taken.
//   - A two-state busy tracker for the HI/LO unit.
//   - Optional stall/flush performance counters, built only when the macro
//     HAZARD_PERF_CNT_EN is defined; otherwise the counters read as 0.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   rs_d, rt_d, use_rs_d, use_rt_d  ID source registers and their use flags
//   branch_d, likely_d, taken_d     ID branch, branch-likely, resolved taken
//   md_use_d                        ID instruction touches the HI/LO unit
//   rs_e, rt_e, wa_e, we_e          EX sources, destination, write enable
//   mem_to_reg_e                    EX instruction is a load
//   md_start_e, md_div_e            mul/div issuing in EX, and it is a divide
//   wa_m, we_m, mem_to_reg_m        MEM destination, write enable, is load
//   wa_w, we_w                      WB destination, write enable
//   fwd_a_d, fwd_b_d                ID forward selects
//   fwd_a_e, fwd_b_e                EX forward selects
//   stall_pc, stall_if_id           hold PC and IF/ID register
//   flush_id_ex, flush_if_id        bubble into EX, squash IF/ID
//   md_busy                         HI/LO unit busy
//   stall_cnt, flush_cnt            performance counters
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int ADDR_W  = 5,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_d,
    input  logic [ADDR_W-1:0] rt_d,
    input  logic              use_rs_d,
    input  logic              use_rt_d,
    input  logic              branch_d,
    input  logic              likely_d,
    input  logic              taken_d,
    input  logic              md_use_d,
    input  logic [ADDR_W-1:0] rs_e,
    input  logic [ADDR_W-1:0] rt_e,
    input  logic [ADDR_W-1:0] wa_e,
    input  logic              we_e,
    input  logic              mem_to_reg_e,
    input  logic              md_start_e,
    input  logic              md_div_e,
    input  logic [ADDR_W-1:0] wa_m,
    input  logic [ADDR_W-1:0] wa_w,
    input  logic              we_m,
    input  logic              we_w,
    input  logic              mem_to_reg_m,
    output logic [1:0]        fwd_a_d,
    output logic [1:0]        fwd_b_d,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              flush_id_ex,
    output logic              flush_if_id,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);

    // The counter holds "cycles left after this one", so a latency of N
    // loads N-1 and the unit reads busy for exactly N cycles.
    localparam logic [LAT_W-1:0] MUL_LOAD = LAT_W'(MUL_LAT - 1);
    localparam logic [LAT_W-1:0] DIV_LOAD = LAT_W'(DIV_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    typedef enum logic {
        IDLE,
        BUSY
    } md_state_t;

    md_state_t        state, state_next;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_next;

    logic ld_use_stall;
    logic br_stall;
    logic md_stall;
    logic stall;

    // Forward select for one source. Register 0 is hard-wired and never
    // forwards. When the consumer sits in ID, a load in MEM has no data yet,
    // so the MEM path is skipped (the branch stall covers that case).
    function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] src,
                                           input logic              block_mem_load);
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (we_m && (wa_m == src) && !block_mem_load)
                sel = 2'b01;
            else if (we_w && (wa_w == src))
                sel = 2'b10;
        end
        return sel;
    endfunction

    // A branch compares in ID, so any used source produced by the EX
    // instruction or by a load still in MEM cannot be forwarded in time.
    function automatic logic br_dep(input logic [ADDR_W-1:0] src,
                                    input logic              used);
        return used && (src != '0) &&
               ((we_e && (src == wa_e)) || (mem_to_reg_m && (src == wa_m)));
    endfunction

    // Forwarding muxes for both stages.
    always_comb begin
        fwd_a_e = fwd_sel(rs_e, 1'b0);
        fwd_b_e = fwd_sel(rt_e, 1'b0);
        fwd_a_d = fwd_sel(rs_d, mem_to_reg_m);
        fwd_b_d = fwd_sel(rt_d, mem_to_reg_m);
    end

    // Hazard detection. A HI/LO access must also wait when an operation is
    // being issued this very cycle, before md_busy has had a chance to rise.
    always_comb begin
        ld_use_stall = mem_to_reg_e && (wa_e != '0) &&
                       ((use_rs_d && (rs_d == wa_e)) ||
                        (use_rt_d && (rt_d == wa_e)));
        br_stall     = branch_d && (br_dep(rs_d, use_rs_d) || br_dep(rt_d, use_rt_d));
        md_stall     = md_use_d && (md_busy || md_start_e);
        stall        = ld_use_stall || br_stall || md_stall;
    end

    assign stall_pc    = stall;
    assign stall_if_id = stall;
    assign flush_id_ex = stall;

    // A not-taken branch-likely annuls its delay slot, but only once the
    // branch itself actually leaves ID.
    assign flush_if_id = branch_d && likely_d && !taken_d && !stall;

    // HI/LO busy tracker state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_next;
            lat_cnt <= lat_cnt_next;
        end
    end

    // Next-state logic. A new issue always reloads the counter, so an issue
    // during BUSY restarts the wait with the new operation's latency.
    always_comb begin
        state_next   = state;
        lat_cnt_next = lat_cnt;
        case (state)
            IDLE: begin
                if (md_start_e) begin
                    state_next   = BUSY;
                    lat_cnt_next = md_div_e ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                if (md_start_e) begin
                    lat_cnt_next = md_div_e ? DIV_LOAD : MUL_LOAD;
                end else if (lat_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    lat_cnt_next = lat_cnt - LAT_ONE;
                end
            end
            default: begin
                state_next   = IDLE;
                lat_cnt_next = '0;
            end
        endcase
    end

    assign md_busy = (state == BUSY);

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Saturating event counters: one per stalled cycle and one per
    // delay-slot squash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_ONE;
            if (flush_if_id && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. Inputs change just after the falling
// edge and outputs are sampled 1 ns later. A behavioural model tracks the
// HI/LO unit as "busy cycles remaining" and the perf counters as plain
// event tallies; directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int ADDR_W  = 5;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 32;
    localparam int CNT_W   = 32;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] rs_d, rt_d, rs_e, rt_e, wa_e, wa_m, wa_w;
    logic              use_rs_d, use_rt_d, branch_d, likely_d, taken_d, md_use_d;
    logic              we_e, mem_to_reg_e, md_start_e, md_div_e;
    logic              we_m, we_w, mem_to_reg_m;
    logic [1:0]        fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e;
    logic              stall_pc, stall_if_id, flush_id_ex, flush_if_id, md_busy;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int                assertions_cnt = 0;
    int                failures_cnt   = 0;

    int                busy_left;
    logic [CNT_W-1:0]  stall_tally;
    logic [CNT_W-1:0]  flush_tally;
    logic              exp_stall;
    logic              exp_flush;

    hazard_ctrl #(
        .ADDR_W (ADDR_W),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs_d        (rs_d),
        .rt_d        (rt_d),
        .use_rs_d    (use_rs_d),
        .use_rt_d    (use_rt_d),
        .branch_d    (branch_d),
        .likely_d    (likely_d),
        .taken_d     (taken_d),
        .md_use_d    (md_use_d),
        .rs_e        (rs_e),
        .rt_e        (rt_e),
        .wa_e        (wa_e),
        .we_e        (we_e),
        .mem_to_reg_e(mem_to_reg_e),
        .md_start_e  (md_start_e),
        .md_div_e    (md_div_e),
        .wa_m        (wa_m),
        .wa_w        (wa_w),
        .we_m        (we_m),
        .we_w        (we_w),
        .mem_to_reg_m(mem_to_reg_m),
        .fwd_a_d     (fwd_a_d),
        .fwd_b_d     (fwd_b_d),
        .fwd_a_e     (fwd_a_e),
        .fwd_b_e     (fwd_b_e),
        .stall_pc    (stall_pc),
        .stall_if_id (stall_if_id),
        .flush_id_ex (flush_id_ex),
        .flush_if_id (flush_if_id),
        .md_busy     (md_busy),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        assertions_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: who supplies a source register. A producer only counts if
    // it writes a nonzero register; the nearer stage wins; a load in MEM is
    // not yet usable by the branch comparator in ID.
    function automatic logic [1:0] modelFwd(input logic [ADDR_W-1:0] src,
                                            input bit to_id);
        if (src == 0) return 2'b00;
        if (we_m && wa_m == src && !(to_id && mem_to_reg_m)) return 2'b01;
        if (we_w && wa_w == src) return 2'b10;
        return 2'b00;
    endfunction

    // Reference: does the ID instruction have to wait this cycle?
    function automatic logic modelStall();
        bit load_use, branch_wait, hilo_wait;
        load_use = 0;
        branch_wait = 0;
        if (mem_to_reg_e && wa_e != 0) begin
            if (use_rs_d && rs_d == wa_e) load_use = 1;
            if (use_rt_d && rt_d == wa_e) load_use = 1;
        end
        if (branch_d) begin
            if (use_rs_d && rs_d != 0 &&
                ((we_e && rs_d == wa_e) || (mem_to_reg_m && rs_d == wa_m))) branch_wait = 1;
            if (use_rt_d && rt_d != 0 &&
                ((we_e && rt_d == wa_e) || (mem_to_reg_m && rt_d == wa_m))) branch_wait = 1;
        end
        hilo_wait = md_use_d && (busy_left > 0 || md_start_e);
        return load_use || branch_wait || hilo_wait;
    endfunction

    // Compare every output with the model.
    task automatic checkAll(input string tag);
        logic [CNT_W-1:0] exp_sc, exp_fc;
        exp_stall = modelStall();
        exp_flush = branch_d && likely_d && !taken_d && !exp_stall;
`ifdef HAZARD_PERF_CNT_EN
        exp_sc = stall_tally;
        exp_fc = flush_tally;
`else
        exp_sc = '0;
        exp_fc = '0;
`endif
        checkOutput({tag, ":fwd_a_d"}, fwd_a_d, modelFwd(rs_d, 1));
        checkOutput({tag, ":fwd_b_d"}, fwd_b_d, modelFwd(rt_d, 1));
        checkOutput({tag, ":fwd_a_e"}, fwd_a_e, modelFwd(rs_e, 0));
        checkOutput({tag, ":fwd_b_e"}, fwd_b_e, modelFwd(rt_e, 0));
        checkOutput({tag, ":stall_pc"}, stall_pc, exp_stall);
        checkOutput({tag, ":stall_if_id"}, stall_if_id, exp_stall);
        checkOutput({tag, ":flush_id_ex"}, flush_id_ex, exp_stall);
        checkOutput({tag, ":flush_if_id"}, flush_if_id, exp_flush);
        checkOutput({tag, ":md_busy"}, md_busy, busy_left > 0);
        checkOutput({tag, ":stall_cnt"}, stall_cnt, exp_sc);
        checkOutput({tag, ":flush_cnt"}, flush_cnt, exp_fc);
    endtask

    // Advance the model across a rising edge using the inputs held there.
    task automatic updateModel();
        if (md_start_e)
            busy_left = md_div_e ? DIV_LAT : MUL_LAT;
        else if (busy_left > 0)
            busy_left--;
        if (exp_stall && stall_tally != '1) stall_tally++;
        if (exp_flush && flush_tally != '1) flush_tally++;
    endtask

    task automatic settle(input string tag);
        #1;
        checkAll(tag);
    endtask

    task automatic advance();
        @(posedge clk);
        updateModel();
        @(negedge clk);
    endtask

    task automatic clearInputs();
        {rs_d, rt_d, rs_e, rt_e, wa_e, wa_m, wa_w} = '0;
        {use_rs_d, use_rt_d, branch_d, likely_d, taken_d, md_use_d} = '0;
        {we_e, mem_to_reg_e, md_start_e, md_div_e, we_m, we_w, mem_to_reg_m} = '0;
    endtask

    // Random pipeline contents; small register range so hits are common.
    task automatic applyStimulus();
        rs_d = ADDR_W'($urandom_range(0, 3));
        rt_d = ADDR_W'($urandom_range(0, 3));
        rs_e = ADDR_W'($urandom_range(0, 3));
        rt_e = ADDR_W'($urandom_range(0, 3));
        wa_e = ADDR_W'($urandom_range(0, 3));
        wa_m = ADDR_W'($urandom_range(0, 3));
        wa_w = ADDR_W'($urandom_range(0, 3));
        use_rs_d     = 1'($urandom);
        use_rt_d     = 1'($urandom);
        branch_d     = 1'($urandom);
        likely_d     = 1'($urandom);
        taken_d      = 1'($urandom);
        md_use_d     = ($urandom_range(0, 3) == 0);
        we_e         = 1'($urandom);
        mem_to_reg_e = 1'($urandom);
        md_start_e   = ($urandom_range(0, 11) == 0);
        md_div_e     = 1'($urandom);
        we_m         = 1'($urandom);
        we_w         = 1'($urandom);
        mem_to_reg_m = 1'($urandom);
    endtask

    // Pulse reset between clock edges; everything sequential must clear
    // while rst_n is still low.
    task automatic resetPulse(input string tag);
        rst_n = 1'b0;
        #2;
        busy_left   = 0;
        stall_tally = '0;
        flush_tally = '0;
        checkAll(tag);
        checkOutput({tag, ":busy_in_reset"}, md_busy, 1'b0);
        rst_n = 1'b1;
        advance();
    endtask

    initial begin
        busy_left   = 0;
        stall_tally = '0;
        flush_tally = '0;
        exp_stall   = 1'b0;
        exp_flush   = 1'b0;
        rst_n = 1'b0;
        clearInputs();
        @(negedge clk);
        resetPulse("reset");

        // EX forwarding priority and register 0.
        clearInputs();
        rs_e = 3; wa_m = 3; we_m = 1; wa_w = 3; we_w = 1;
        settle("fwd_mem");
        checkOutput("fwd_mem_direct", fwd_a_e, 2'b01);
        we_m = 0;
        settle("fwd_wb");
        checkOutput("fwd_wb_direct", fwd_a_e, 2'b10);
        rs_e = 0;
        settle("fwd_r0");
        checkOutput("fwd_r0_direct", fwd_a_e, 2'b00);
        advance();

        // Load-use, then the load moves on to MEM.
        clearInputs();
        mem_to_reg_e = 1; wa_e = 8; rt_d = 8; use_rt_d = 1;
        settle("load_use");
        checkOutput("load_use_direct", stall_pc, 1'b1);
        advance();
        clearInputs();
        rt_d = 8; use_rt_d = 1; wa_m = 8; we_m = 1; mem_to_reg_m = 1;
        settle("load_in_mem");
        checkOutput("load_in_mem_stall", stall_pc, 1'b0);
        checkOutput("load_in_mem_no_id_fwd", fwd_b_d, 2'b00);
        advance();
        clearInputs();
        mem_to_reg_e = 1; wa_e = 8; rt_d = 8; use_rt_d = 0;
        settle("load_unused");
        checkOutput("load_unused_direct", stall_pc, 1'b0);
        advance();

        // Divide: busy cycles 1..32, HI/LO reader stalls cycles 0..32.
        for (int k = 0; k <= 33; k++) begin
            clearInputs();
            md_start_e = (k == 0); md_div_e = 1; md_use_d = 1;
            settle("div");
            checkOutput("div_busy", md_busy, (k >= 1 && k <= 32));
            checkOutput("div_stall", stall_pc, (k <= 32));
            advance();
        end

        // Multiply, restarted as a divide in its third busy cycle.
        for (int k = 0; k <= 37; k++) begin
            clearInputs();
            md_start_e = (k == 0 || k == 3); md_div_e = (k == 3);
            settle("restart");
            checkOutput("restart_busy", md_busy, (k >= 1 && k <= 35));
            advance();
        end

        // Branch-likely not taken; then with an EX dependency.
        clearInputs();
        branch_d = 1; likely_d = 1; taken_d = 0;
        settle("likely");
        checkOutput("likely_flush", flush_if_id, 1'b1);
        rs_d = 4; use_rs_d = 1; wa_e = 4; we_e = 1;
        settle("likely_dep");
        checkOutput("likely_dep_flush", flush_if_id, 1'b0);
        checkOutput("likely_dep_stall", stall_pc, 1'b1);
        advance();

        // Perf counters: 3 stalls and 1 flush from a clean start.
        resetPulse("perf_reset");
        for (int k = 0; k < 3; k++) begin
            clearInputs();
            mem_to_reg_e = 1; wa_e = 8; rt_d = 8; use_rt_d = 1;
            settle("perf_stall");
            advance();
        end
        clearInputs();
        branch_d = 1; likely_d = 1;
        settle("perf_flush");
        advance();
        clearInputs();
        settle("perf_count");
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("perf_stall_cnt", stall_cnt, 3);
        checkOutput("perf_flush_cnt", flush_cnt, 1);
`else
        checkOutput("perf_stall_cnt", stall_cnt, 0);
        checkOutput("perf_flush_cnt", flush_cnt, 0);
`endif

        // Reset in the middle of a multiply aborts it.
        md_start_e = 1;
        advance();
        clearInputs();
        settle("mid_busy");
        checkOutput("mid_busy_direct", md_busy, 1'b1);
        advance();
        resetPulse("mid_busy_reset");
        for (int k = 0; k < 6; k++) begin
            clearInputs();
            settle("after_abort");
            checkOutput("after_abort_busy", md_busy, 1'b0);
            advance();
        end

        // Randomized run against the model.
        for (int k = 0; k < 400; k++) begin
            applyStimulus();
            settle("rand");
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions_cnt, failures_cnt);
        $finish;
    end

endmodule
